// File: rtl/riscv_pkg.sv
// Shared RV32 constants for the execute-stage M-extension sequencer.
package riscv_pkg;

    // Major opcode and funct7 that together identify an RV32M instruction
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // funct3 selects within the M extension; bit 2 splits multiply from divide
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Sequencer state encoding
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

endpackage

// File: rtl/ex_muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer for the EX stage.
// Works on operand magnitudes (one bit per cycle) and applies the sign on
// the final iteration; holds the pipeline while busy and pulses done once.
module ex_muldiv_sequencer
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              CW       = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    // Two's-complement negation applied only when the sign flag is set
    function automatic logic [2*XLEN-1:0] neg_if(input logic [2*XLEN-1:0] v,
                                                 input logic flag);
        return flag ? (~v + 1'b1) : v;
    endfunction

    md_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;     // multiplicand (MUL) or divisor (DIV) magnitude
    logic              neg_q, neg_d;       // product / quotient sign
    logic              negr_q, negr_d;     // remainder sign
    logic [2*XLEN-1:0] acc_q, acc_d;       // {hi, lo}: product, or {remainder, dividend/quotient}
    logic [XLEN-1:0]   result_q, result_d;

    // Operand decode for the accepting cycle
    logic              a_signed, b_signed, sa, sb, div_zero, div_ovf;
    logic [XLEN-1:0]   mag_a, mag_b;

    // One-iteration datapath results
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, prod_fix;
    logic [XLEN:0]     div_shift, div_trial;
    logic              div_ok;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   div_sel;
    logic              div_neg;

    // Decode signedness, magnitudes and the early-exit divide cases
    always_comb begin
        a_signed = (funct3 != F3_MULHU) && (funct3 != F3_DIVU) && (funct3 != F3_REMU);
        b_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                   (funct3 == F3_DIV) || (funct3 == F3_REM);
        sa       = a_signed & op_a[XLEN-1];
        sb       = b_signed & op_b[XLEN-1];
        mag_a    = sa ? (~op_a + 1'b1) : op_a;
        mag_b    = sb ? (~op_b + 1'b1) : op_b;
        div_zero = (op_b == '0);
        div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                   (op_a == INT_MIN) && (op_b == '1);
    end

    // Single shift-add / restoring-subtract step plus final sign fixup
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        prod_fix  = neg_if(mul_next, neg_q);

        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        div_ok    = ~div_trial[XLEN];
        div_next  = {(div_ok ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0]),
                     acc_q[XLEN-2:0], div_ok};
        div_sel   = f3_q[1] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
        div_neg   = f3_q[1] ? negr_q : neg_q;
    end

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        negr_d   = negr_q;
        acc_d    = acc_q;
        result_d = result_q;
        stall    = 1'b0;
        done     = 1'b0;

        unique case (state_q)
            MD_IDLE: begin
                if (start && !flush) begin
                    stall  = 1'b1;
                    f3_d   = funct3;
                    cnt_d  = '0;
                    neg_d  = sa ^ sb;
                    negr_d = sa;
                    if (!funct3[2]) begin
                        opnd_d  = mag_a;
                        acc_d   = {{XLEN{1'b0}}, mag_b};
                        state_d = MD_MUL;
                    end else if (div_zero) begin
                        result_d = funct3[1] ? op_a : '1;
                        state_d  = MD_DONE;
                    end else if (div_ovf) begin
                        result_d = funct3[1] ? '0 : INT_MIN;
                        state_d  = MD_DONE;
                    end else begin
                        opnd_d  = mag_b;
                        acc_d   = {{XLEN{1'b0}}, mag_a};
                        state_d = MD_DIV;
                    end
                end
            end
            MD_MUL: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = MD_IDLE;
                end else begin
                    acc_d = mul_next;
                    if (cnt_q == CNT_LAST) begin
                        result_d = (f3_q == F3_MUL) ? prod_fix[XLEN-1:0]
                                                    : prod_fix[2*XLEN-1:XLEN];
                        state_d  = MD_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            MD_DIV: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = MD_IDLE;
                end else begin
                    acc_d = div_next;
                    if (cnt_q == CNT_LAST) begin
                        result_d = XLEN'(neg_if({{XLEN{1'b0}}, div_sel}, div_neg));
                        state_d  = MD_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            MD_DONE: begin
                // Instruction has already retired; flush cannot suppress the pulse
                done    = 1'b1;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            negr_q   <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            negr_q   <= negr_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Scoreboard bench for ex_muldiv_sequencer: stimulus pushes expected results,
// a negedge monitor pops and checks value, latency and stall on every done.
module tb_ex_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic        flush;
    logic        stall, done;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] res;
        int          start_cyc;
        int          lat;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] last_exp = 32'h0;

    ex_muldiv_sequencer #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference model: RV32M semantics in plain 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f3,
                                              input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (f3)
            3'd0: begin p = longint'(sa * sb);  return p[31:0];  end
            3'd1: begin p = longint'(sa * sb);  return p[63:32]; end
            3'd2: begin p = longint'(sa * longint'(ub)); return p[63:32]; end
            3'd3: begin p = ua * ub;            return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = longint'(sa / sb); return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = longint'(sa % sb); return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one op, push its expectation, then wait (bounded) for the monitor to retire it
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   waited;
        @(posedge clk); #1;
        start = 1'b1; funct3 = f3; op_a = a; op_b = b;
        e.res = ref_model(f3, a, b);
        e.start_cyc = cyc;
        e.lat = ref_latency(f3, a, b);
        e.f3 = f3; e.a = a; e.b = b;
        sb_q.push_back(e);
        last_exp = e.res;
        @(posedge clk); #1;
        start = 1'b0;
        // Busy-time input changes must be ignored
        funct3 = 3'($urandom_range(0, 7)); op_a = $urandom; op_b = $urandom;
        waited = 0;
        while (sb_q.size() != 0 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        if (sb_q.size() != 0) begin
            tests++; fails++;
            $display("[TB] FAIL timeout: no done for f3=%0d a=%08h b=%08h", f3, a, b);
            sb_q.delete();
        end
    endtask

    // Monitor: stall while an op is outstanding, compare on each done pulse
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (sb_q.size() == 0) begin
                    tests++; fails++;
                    $display("[TB] FAIL unexpected_done: got result %08h expected no pulse", result);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    $display("[TB] f3=%0d a=%08h b=%08h -> %08h (exp %08h) latency %0d",
                             e.f3, e.a, e.b, result, e.res, cyc - e.start_cyc);
                    check("result", result, e.res);
                    check("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
                    check("stall_at_done", {31'b0, stall}, 32'h0);
                end
            end else if (sb_q.size() != 0) begin
                check("stall_busy", {31'b0, stall}, 32'h1);
            end
        end
    end

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = 3'd0; op_a = 32'h0; op_b = 32'h0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_stall", {31'b0, stall}, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        check("reset_result", result, 32'h0);
        rst_n = 1'b1;

        // Directed cases
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd5, 32'd100, 32'd7);
        run_op(3'd7, 32'd100, 32'd7);
        run_op(3'd5, 32'd5, 32'd0);
        run_op(3'd6, 32'd5, 32'd0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        // Flush in cycle 10 of a DIV: back to idle, no pulse, result held
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_stall", {31'b0, stall}, 32'h0);
        check("flush_done", {31'b0, done}, 32'h0);
        check("flush_result", result, last_exp);
        run_op(3'd0, 32'd3, 32'd4);

        // Start together with flush in idle: not accepted
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9;
        #1 check("start_flush_stall", {31'b0, stall}, 32'h0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("start_flush_idle", {31'b0, stall}, 32'h0);
        repeat (3) @(posedge clk);

        // Asynchronous reset in cycle 15 of a MUL
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd0; op_a = 32'd5; op_b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_done", {31'b0, done}, 32'h0);
        check("async_rst_stall", {31'b0, stall}, 32'h0);
        check("async_rst_result", result, 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        run_op(3'd0, 32'd2, 32'd2);

        // Randomised ops biased towards boundary operands
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick_val(), pick_val());
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_sequencer.md
Name: ex_muldiv_sequencer

Overview:
Multi-cycle controller for RV32M operations in the execute stage. It accepts a MUL/DIV/REM instruction with its forwarded operands and stalls the pipeline while an iterative shift-add multiplier or restoring divider runs. It then presents the result for one cycle alongside the ALU result path. It sits beside the EX ALU and drives the EX/IF/ID stall request.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  valid M-extension op present in EX (opcode 0110011, funct7 0000001)
funct3  input  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  XLEN  forwarded rs1 value
op_b  input  XLEN  forwarded rs2 value
flush  input  1  synchronous abort (branch/exception flush of EX)
stall  output  1  pipeline hold request (combinational)
done  output  1  result valid, one-cycle pulse
result  output  XLEN  registered result, valid while done=1

Behaviour:
- Reset (reset=0, asynchronous) forces the following, regardless of state mid-operation:
  - state=IDLE; counter, accumulators and result=0; done=0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - stall = start & ~flush.
  - On start & ~flush, latch funct3 and operand magnitudes, plus a sign-fixup flag per the funct3 signedness rules. MULHSU: op_a signed, op_b unsigned. Clear the counter.
  - Next state: MUL for funct3[2]=0; DIV for funct3[2]=1, except in the special cases below.
- Special cases go IDLE->DONE directly and load result on the same edge:
  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> op_a.
  - Signed overflow (DIV/REM with op_a=0x80000000, op_b=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- MUL:
  - Radix-2 shift-add on unsigned magnitudes into a 2*XLEN product, one bit per cycle, for XLEN cycles.
  - On the last cycle, apply two's-complement negation of the 2*XLEN product if the sign flag is set.
  - Select low half (MUL) or high half (MULH*) into result. Next state DONE.
- DIV:
  - Restoring division on magnitudes, one quotient bit per cycle, for XLEN cycles.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
  - Load the selected value into result. Next state DONE.
- While in MUL/DIV: stall=1; done=0; input changes are ignored.
- DONE:
  - done=1, stall=0. The pipeline advances on this edge.
  - Next state is unconditionally IDLE. A start in the following cycle is a new instruction.
- Latency, with the start cycle as cycle 0:
  - Normal op: done in cycle XLEN+1 (33); stall high in cycles 0..XLEN (33 cycles).
  - Special case: done in cycle 1; stall high in cycle 0 only.
- Flush:
  - In any state except DONE: next state IDLE, no done pulse, result holds its previous value.
  - In DONE: done still pulses (the instruction already retired to EX/MEM), next state IDLE.
  - Flush and start together in IDLE: op not accepted; stall=0.
- Counter is clog2(XLEN)+1 bits wide, compared against XLEN-1. No wrap-around beyond the last iteration.
- result holds its value outside DONE. Consumers must qualify it with done.

Decomposition:
- Shared package riscv_pkg holds:
  - M-extension funct3 localparams (F3_MUL..F3_REMU).
  - OPCODE_OP and FUNCT7_MULDIV constants.
  - The muldiv state encoding (2-bit: IDLE=0, MUL=1, DIV=2, DONE=3).
- Single module; no sub-module required. Sign fixup (negate-if-flag) is a local function.

Test Plan:
- MUL 7 * 0xFFFFFFFD (-3), start in cycle 0 -> stall high cycles 0..32; done=1 in cycle 33 with result 0xFFFFFFEB.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -7 % 2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100%7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both with done in cycle 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, done in cycle 1.
- Flush at cycle 10 of a DIV -> state IDLE in cycle 11, stall=0, no done pulse, result unchanged; a new MUL 3*4 started next cycle -> 12.
- Reset driven low in cycle 15 of a MUL -> done=0, stall=0 (start low), result=0 immediately (asynchronous); after release, start MUL 2*2 -> 4 in cycle 33.
